// File: rtl/goods_sort_sched.sv
// Shared-sorter scheduler: round-robin admission of two inspection stations into
// one quality sorter feeding two registered belts. Counters built only with GOODS_SORT_STATS_EN.
module goods_sort_sched #(
    parameter logic [6:0] QUAL_THRESH = 7'd61,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_en,
    input  logic             req0_valid,
    input  logic [6:0]       req0_quality,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [6:0]       req1_quality,
    output logic             req1_ready,
    output logic             valid_belt_a,
    output logic [6:0]       belt_a,
    input  logic             belt_a_ready,
    output logic             valid_belt_b,
    output logic [6:0]       belt_b,
    input  logic             belt_b_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic {S0 = 1'b0, S1 = 1'b1} grant_e;

    grant_e     last_grant_r;
    logic       valid_a_r, valid_b_r;
    logic [6:0] belt_a_r, belt_b_r;

    logic       a_free_s, b_free_s;
    logic       dst0_a_s, dst1_a_s;
    logic       elig0_s, elig1_s;
    logic       gnt0_s, gnt1_s;
    logic       load_a_s, load_b_s;
    logic [6:0] gnt_q_s;

    function automatic logic goes_to_a(input logic [6:0] q);
        return (q >= QUAL_THRESH);
    endfunction

    // Eligibility and round-robin grant; ready is held low while in reset.
    always_comb begin
        a_free_s = !valid_a_r || belt_a_ready;
        b_free_s = !valid_b_r || belt_b_ready;
        dst0_a_s = goes_to_a(req0_quality);
        dst1_a_s = goes_to_a(req1_quality);
        elig0_s  = rst_n && line_en && req0_valid && (dst0_a_s ? a_free_s : b_free_s);
        elig1_s  = rst_n && line_en && req1_valid && (dst1_a_s ? a_free_s : b_free_s);
        gnt0_s   = 1'b0;
        gnt1_s   = 1'b0;
        case (last_grant_r)
            S1: begin
                if (elig0_s) gnt0_s = 1'b1;
                else         gnt1_s = elig1_s;
            end
            S0: begin
                if (elig1_s) gnt1_s = 1'b1;
                else         gnt0_s = elig0_s;
            end
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
        if (gnt1_s) begin
            gnt_q_s  = req1_quality;
            load_a_s = dst1_a_s;
            load_b_s = !dst1_a_s;
        end else if (gnt0_s) begin
            gnt_q_s  = req0_quality;
            load_a_s = dst0_a_s;
            load_b_s = !dst0_a_s;
        end else begin
            gnt_q_s  = 7'd0;
            load_a_s = 1'b0;
            load_b_s = 1'b0;
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Arbiter history and the two one-entry belt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= S1;
            valid_a_r    <= 1'b0;
            valid_b_r    <= 1'b0;
            belt_a_r     <= 7'd0;
            belt_b_r     <= 7'd0;
        end else begin
            if (gnt0_s)      last_grant_r <= S0;
            else if (gnt1_s) last_grant_r <= S1;
            if (load_a_s) begin
                belt_a_r  <= gnt_q_s;
                valid_a_r <= 1'b1;
            end else if (belt_a_ready) begin
                valid_a_r <= 1'b0;
            end
            if (load_b_s) begin
                belt_b_r  <= gnt_q_s;
                valid_b_r <= 1'b1;
            end else if (belt_b_ready) begin
                valid_b_r <= 1'b0;
            end
        end
    end

    assign valid_belt_a = valid_a_r;
    assign valid_belt_b = valid_b_r;
    assign belt_a       = belt_a_r;
    assign belt_b       = belt_b_r;

`ifdef GOODS_SORT_STATS_EN
    logic [CNT_W-1:0] cnt_a_r, cnt_b_r;

    // Delivered-item counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_r <= '0;
            cnt_b_r <= '0;
        end else begin
            if (valid_a_r && belt_a_ready) cnt_a_r <= cnt_a_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (valid_b_r && belt_b_ready) cnt_b_r <= cnt_b_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_a = cnt_a_r;
    assign cnt_b = cnt_b_r;
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

endmodule

// File: doc/goods_sort_sched.md
# goods_sort_sched

Shared-sorter scheduler for the goods line: two inspection stations present graded items, and a round-robin arbiter admits at most one item per cycle into a single quality sorter. The sorter routes each item to belt A (quality at or above threshold) or belt B through a one-entry output register per belt, with downstream backpressure. It sits between the inspection stations and the belt drives, replacing direct station-to-belt wiring.

## Interface
- QUAL_THRESH, 61: items with quality >= QUAL_THRESH go to belt A, otherwise to belt B.
- CNT_W, 16: width of the per-belt item counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- line_en  in  1  1 = admit new items; 0 = hold stations, belts still drain.
- req0_valid  in  1  station 0 has an item.
- req0_quality  in  7  station 0 item quality, 0..127.
- req0_ready  out  1  station 0 item accepted this cycle.
- req1_valid / req1_quality / req1_ready: same for station 1.
- valid_belt_a  out  1  belt A register holds an item.
- belt_a  out  7  belt A item quality.
- belt_a_ready  in  1  belt A consumes the item this cycle.
- valid_belt_b / belt_b / belt_b_ready: same for belt B.
- cnt_a  out  CNT_W  items delivered on belt A.
- cnt_b  out  CNT_W  items delivered on belt B.

## Operation
- Transfer on a station when reqN_valid && reqN_ready; on a belt when valid_belt_x && belt_x_ready.
- Destination of station N: A if reqN_quality >= QUAL_THRESH, else B (unsigned 7-bit compare).
- Belt x is free in a cycle if !valid_belt_x, or valid_belt_x && belt_x_ready (drain and refill same cycle permitted).
- Station N is eligible iff line_en && reqN_valid && its destination belt is free.
- Arbiter state: last_grant (1 bit), values S0/S1. Priority goes to the station other than last_grant; if it is not eligible, the other station wins if eligible. No head-of-line blocking across stations.
- Exactly one reqN_ready high when any station is eligible; none otherwise. reqN_ready is combinational from current inputs and state.
- On accept: destination belt register loads quality, its valid sets; last_grant <= granted station. No accept: last_grant unchanged.
- Belt register clears valid on consume with no refill; data holds its last value while valid is low.
- Counters: increment by 1 on each belt transfer; wrap at 2^CNT_W-1 -> 0.
- line_en low mid-stream: no new accepts; loaded belt registers still present and drain normally.

## Timing
- Reset (async assert, synchronous release at next clk): valid_belt_a/b = 0, belt_a/b = 0, cnt_a/b = 0, last_grant = S1 (station 0 gets first priority); reqN_ready = 0 while in reset.
- Latency: item accepted at edge N appears on valid_belt_x/belt_x after edge N (1 cycle).
- Throughput: 1 item/cycle total with both belts ready; sustained 1 item/cycle to a single belt with belt_x_ready held high.
- Belt outputs are registered; belt data/valid are stable while valid && !ready.
- Reset mid-operation: in-flight belt items are discarded; no partial state survives.

## Configuration
- GOODS_SORT_STATS_EN defined: cnt_a/cnt_b implemented as above.
- Not defined: counter registers omitted; cnt_a/cnt_b tied to 0. All other behaviour identical.

## Test plan
- Reset, then station 0 presents 80, belts ready -> req0_ready=1 that cycle; next cycle valid_belt_a=1, belt_a=80, valid_belt_b=0; cnt_a=1 after consume.
- Both stations valid every cycle, qualities 70 (st0) and 20 (st1), belts ready -> grants alternate 0,1,0,1 starting with station 0; belt A and B each valid every other cycle.
- belt_a_ready=0, belt A loaded; st0=90, st1=10 -> st0 held (ready=0), st1 accepted to belt B; when belt_a_ready rises, st0 accepted in that same cycle.
- Threshold boundary: qualities 60, 61, 127, 0 -> belts B, A, A, B respectively.
- line_en=0 with belt A holding 100 and both stations valid -> no reqN_ready; belt A still delivers 100 on belt_a_ready=1; assert rst_n low mid-stream -> all valids 0, counters 0 immediately.
- With GOODS_SORT_STATS_EN, deliver 2^CNT_W items to belt A (CNT_W=4 override: 16) -> cnt_a wraps to 0; without macro cnt_a stays 0.
